// File: rtl/sfp_link_seq_pkg.sv
// Shared types and widths for the SFP+ link bring-up sequencer.
// Contents: sequencer state encoding, timer/counter widths, timer load helper.
package sfp_link_seq_pkg;

    localparam int unsigned TIMER_W = 24;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned DEB_W   = 16;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_WAIT_CLK = 3'd1,
        ST_PHY_RST  = 3'd2,
        ST_TX_ON    = 3'd3,
        ST_WAIT_SIG = 3'd4,
        ST_LINK_UP  = 3'd5,
        ST_FAULT    = 3'd6,
        ST_LOCKOUT  = 3'd7
    } state_e;

    // Down-counter load value for a window of 'cyc' cycles; a length of 0 behaves as 1.
    function automatic logic [TIMER_W-1:0] tmr_load(input logic [TIMER_W-1:0] cyc);
        return (cyc == '0) ? '0 : cyc - TIMER_W'(1);
    endfunction

endpackage

// File: rtl/sfp_link_seq_deb.sv
// Two-flop synchroniser followed by a stability filter for one SFP status pin.
// Ports: clk, rst_n (async active-low), din_i (asynchronous pin), dout_o (filtered level).
// dout_o follows the synced pin only after it has differed for DEB_CYCLES consecutive
// cycles; any return to the current filtered level restarts the count.
module sfp_link_seq_deb
    import sfp_link_seq_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = 16'd1000,
    parameter logic             RST_VAL    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic dout_o
);

    localparam logic [DEB_W-1:0] DEB_LAST = (DEB_CYCLES == '0) ? '0 : DEB_CYCLES - DEB_W'(1);

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; flip on the last one.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q >= DEB_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            filt_q  <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = filt_q;

endmodule

// File: rtl/sfp_link_seq.sv
// SFP+ port bring-up sequencer: filters the module status pins, sequences TX_DISABLE
// and the Ethernet core reset, retries on TX fault and reports link/state status.
// Ports: clk100, sys_rst_n (async active-low), sfp_clk_alarm_b, eth0_tx_fault,
//   eth0_rx_los, retry_clr (inputs); eth0_tx_disable, eth_rst, link_up, state[2:0],
//   link_down_cnt[15:0], fault_cnt[15:0] (registered outputs).
// Build option: define SFP_LINK_SEQ_STATS_EN to build the saturating event counters;
//   otherwise link_down_cnt and fault_cnt are tied to zero. The FSM is unaffected.
module sfp_link_seq
    import sfp_link_seq_pkg::*;
#(
    parameter logic [DEB_W-1:0]   DEB_CYCLES   = 16'd1000,
    parameter logic [TIMER_W-1:0] RST_CYCLES   = 24'd256,
    parameter logic [TIMER_W-1:0] TXEN_CYCLES  = 24'd10000,
    parameter logic [TIMER_W-1:0] RETRY_CYCLES = 24'd100000,
    parameter logic [RETRY_W-1:0] MAX_RETRY    = 4'd3
) (
    input  logic             clk100,
    input  logic             sys_rst_n,
    input  logic             sfp_clk_alarm_b,
    input  logic             eth0_tx_fault,
    input  logic             eth0_rx_los,
    input  logic             retry_clr,
    output logic             eth0_tx_disable,
    output logic             eth_rst,
    output logic             link_up,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] link_down_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    // Link must stay up this many cycles (2^24-1 total) before the retry budget refills.
    localparam logic [TIMER_W-1:0] STABLE_LAST = ~TIMER_W'(1);

    logic clk_ok, fault, los;

    // Pessimistic reset levels: alarm active, fault and LOS asserted.
    sfp_link_seq_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_alarm (
        .clk(clk100), .rst_n(sys_rst_n), .din_i(sfp_clk_alarm_b), .dout_o(clk_ok)
    );
    sfp_link_seq_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_fault (
        .clk(clk100), .rst_n(sys_rst_n), .din_i(eth0_tx_fault), .dout_o(fault)
    );
    sfp_link_seq_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_los (
        .clk(clk100), .rst_n(sys_rst_n), .din_i(eth0_rx_los), .dout_o(los)
    );

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TIMER_W-1:0]   stable_q, stable_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 tx_dis_q, eth_rst_q, link_up_q;
    logic [2:0]           state_out_q;
    logic                 tx_en;

    // Next-state, timer and retry bookkeeping.
    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
        retry_d  = retry_q;
        stable_d = '0;
        case (state_q)
            ST_RESET: state_d = ST_WAIT_CLK;
            ST_WAIT_CLK: begin
                if (clk_ok) begin
                    state_d = ST_PHY_RST;
                    timer_d = tmr_load(RST_CYCLES);
                end
            end
            ST_LOCKOUT: begin
                if (retry_clr) begin
                    state_d = ST_WAIT_CLK;
                    retry_d = '0;
                end
            end
            default: begin
                // Active states: clock alarm beats TX fault beats LOS.
                if (!clk_ok) begin
                    state_d = ST_WAIT_CLK;
                end else if (fault && state_q != ST_FAULT) begin
                    state_d = ST_FAULT;
                    timer_d = tmr_load(RETRY_CYCLES);
                    retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
                end else begin
                    case (state_q)
                        ST_PHY_RST: begin
                            if (timer_q == '0) begin
                                state_d = ST_TX_ON;
                                timer_d = tmr_load(TXEN_CYCLES);
                            end
                        end
                        ST_TX_ON: begin
                            if (timer_q == '0) state_d = ST_WAIT_SIG;
                        end
                        ST_WAIT_SIG: begin
                            if (!los) state_d = ST_LINK_UP;
                        end
                        ST_LINK_UP: begin
                            if (los) state_d = ST_WAIT_SIG;
                        end
                        ST_FAULT: begin
                            if (timer_q == '0) begin
                                if (retry_q >= MAX_RETRY) begin
                                    state_d = ST_LOCKOUT;
                                end else begin
                                    state_d = ST_PHY_RST;
                                    timer_d = tmr_load(RST_CYCLES);
                                end
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase
        // A long continuous link refills the retry budget.
        if (state_q == ST_LINK_UP && state_d == ST_LINK_UP) begin
            stable_d = (stable_q == '1) ? stable_q : stable_q + TIMER_W'(1);
            if (stable_q == STABLE_LAST) retry_d = '0;
        end
    end

    always_comb begin
        tx_en = 1'b0;
        case (state_q)
            ST_TX_ON, ST_WAIT_SIG, ST_LINK_UP: tx_en = 1'b1;
            default:                           tx_en = 1'b0;
        endcase
    end

    // State, timers and registered outputs (outputs lag the state by one cycle).
    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_RESET;
            timer_q     <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            tx_dis_q    <= 1'b1;
            eth_rst_q   <= 1'b1;
            link_up_q   <= 1'b0;
            state_out_q <= 3'(ST_RESET);
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            tx_dis_q    <= ~tx_en;
            eth_rst_q   <= ~tx_en;
            link_up_q   <= (state_q == ST_LINK_UP);
            state_out_q <= 3'(state_q);
        end
    end

    assign eth0_tx_disable = tx_dis_q;
    assign eth_rst         = eth_rst_q;
    assign link_up         = link_up_q;
    assign state           = state_out_q;

`ifdef SFP_LINK_SEQ_STATS_EN
    logic [CNT_W-1:0] ldc_q, fc_q;
    logic             ld_evt, fault_evt;

    // LINK_UP only drops to WAIT_SIG on LOS; FAULT entry is the fault event.
    assign ld_evt    = (state_q == ST_LINK_UP) && (state_d == ST_WAIT_SIG);
    assign fault_evt = (state_q != ST_FAULT) && (state_d == ST_FAULT);

    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ldc_q <= '0;
            fc_q  <= '0;
        end else begin
            if (ld_evt && ldc_q != '1)   ldc_q <= ldc_q + CNT_W'(1);
            if (fault_evt && fc_q != '1) fc_q  <= fc_q + CNT_W'(1);
        end
    end

    assign link_down_cnt = ldc_q;
    assign fault_cnt     = fc_q;
`else
    assign link_down_cnt = '0;
    assign fault_cnt     = '0;
`endif

endmodule

// File: tb/tb_sfp_link_seq.sv
// Scoreboard bench for sfp_link_seq: stimulus queues the expected sequence of state
// output changes; a monitor compares each change against the head of the queue.
module tb_sfp_link_seq;

`ifdef SFP_LINK_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk100, sys_rst_n;
    logic        sfp_clk_alarm_b, eth0_tx_fault, eth0_rx_los, retry_clr;
    logic        eth0_tx_disable, eth_rst, link_up;
    logic [2:0]  state;
    logic [15:0] link_down_cnt, fault_cnt;

    sfp_link_seq #(
        .DEB_CYCLES(16'd4), .RST_CYCLES(24'd8), .TXEN_CYCLES(24'd16),
        .RETRY_CYCLES(24'd32), .MAX_RETRY(4'd2)
    ) dut (
        .clk100(clk100), .sys_rst_n(sys_rst_n), .sfp_clk_alarm_b(sfp_clk_alarm_b),
        .eth0_tx_fault(eth0_tx_fault), .eth0_rx_los(eth0_rx_los), .retry_clr(retry_clr),
        .eth0_tx_disable(eth0_tx_disable), .eth_rst(eth_rst), .link_up(link_up),
        .state(state), .link_down_cnt(link_down_cnt), .fault_cnt(fault_cnt)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    typedef struct {
        logic [2:0]  st;
        int          dt;
        logic        tx;
        logic        rst;
        logic        lu;
        logic [15:0] ldc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk100) cyc <= cyc + 1;

    // Queue one expected state change; dt is cycles since the previous change (-1 = any).
    task automatic push(input int st, input int dt, input int ldc, input int fc);
        exp_t e;
        e.st  = 3'(st);
        e.dt  = dt;
        e.tx  = !(st == 3 || st == 4 || st == 5);
        e.rst = e.tx;
        e.lu  = (st == 5);
        e.ldc = STATS ? 16'(ldc) : 16'd0;
        e.fc  = STATS ? 16'(fc)  : 16'd0;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic wait_state(input int s);
        int n = 0;
        while (state != 3'(s) && n < 600) begin
            @(posedge clk100);
            #1;
            n++;
        end
        chk($sformatf("wait_state_%0d", s), 32'(state), 32'(s));
    endtask

    // Monitor: every change of the state output is compared with the queue head.
    initial begin
        logic [2:0] prev;
        exp_t e;
        prev = 3'd0;
        forever begin
            @(negedge clk100);
            if (mon_en && state != prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: state %0d -> %0d at cycle %0d", prev, state, cyc);
                end else begin
                    e = q.pop_front();
                    if (state !== e.st || eth0_tx_disable !== e.tx || eth_rst !== e.rst ||
                        link_up !== e.lu || link_down_cnt !== e.ldc || fault_cnt !== e.fc) begin
                        bad++;
                        $display("FAIL entry_state_%0d: got st=%0d txd=%0b rst=%0b lu=%0b ldc=%0d fc=%0d want st=%0d txd=%0b rst=%0b lu=%0b ldc=%0d fc=%0d",
                                 e.st, state, eth0_tx_disable, eth_rst, link_up, link_down_cnt, fault_cnt,
                                 e.st, e.tx, e.rst, e.lu, e.ldc, e.fc);
                    end
                    if (e.dt >= 0) begin
                        total++;
                        if (cyc - last_cyc != e.dt) begin
                            bad++;
                            $display("FAIL dwell_before_%0d: got %0d want %0d cycles", e.st, cyc - last_cyc, e.dt);
                        end
                    end
                end
                last_cyc = cyc;
            end
            prev = state;
        end
    end

    initial begin
        sys_rst_n = 1'b1; sfp_clk_alarm_b = 1'b1; eth0_tx_fault = 1'b0;
        eth0_rx_los = 1'b0; retry_clr = 1'b0;
        #2 sys_rst_n = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tx_disable", 32'(eth0_tx_disable), 32'd1);
        chk("rst_eth_rst", 32'(eth_rst), 32'd1);
        chk("rst_link_up", 32'(link_up), 32'd0);
        chk("rst_ldc", 32'(link_down_cnt), 32'd0);
        chk("rst_fc", 32'(fault_cnt), 32'd0);
        cycles(3);

        // 1: bring-up with good pins
        push(1, -1, 0, 0); push(2, -1, 0, 0); push(3, 8, 0, 0);
        push(4, 16, 0, 0); push(5, 1, 0, 0);
        mon_en = 1'b1;
        sys_rst_n = 1'b1;
        wait_state(5);

        // 2: short LOS glitch ignored, long pulse drops the link once
        cycles(5);
        eth0_rx_los = 1'b1; cycles(3); eth0_rx_los = 1'b0;
        cycles(20);
        chk("glitch_state", 32'(state), 32'd5);
        chk("glitch_ldc", 32'(link_down_cnt), 32'd0);
        push(4, -1, 1, 0); push(5, -1, 1, 0);
        eth0_rx_los = 1'b1; cycles(6); eth0_rx_los = 1'b0;
        wait_state(4);
        wait_state(5);
        chk("los_ldc", 32'(link_down_cnt), STATS ? 32'd1 : 32'd0);

        // 3: persistent TX fault -> retry -> lockout, then manual clear
        push(1, -1, 1, 0);
        sfp_clk_alarm_b = 1'b0;
        wait_state(1);
        push(2, -1, 1, 0); push(3, 8, 1, 0);
        sfp_clk_alarm_b = 1'b1;
        wait_state(3);
        push(6, -1, 1, 1); push(2, 32, 1, 1); push(6, 1, 1, 2); push(7, 32, 1, 2);
        eth0_tx_fault = 1'b1;
        wait_state(7);
        eth0_tx_fault = 1'b0;
        cycles(12);
        chk("lockout_hold", 32'(state), 32'd7);
        chk("lockout_fc", 32'(fault_cnt), STATS ? 32'd2 : 32'd0);
        push(1, -1, 1, 2); push(2, 1, 1, 2); push(3, 8, 1, 2);
        push(4, 16, 1, 2); push(5, 1, 1, 2);
        retry_clr = 1'b1; cycles(1); retry_clr = 1'b0;
        wait_state(5);

        // 4: clock alarm during FAULT with fault still asserted
        push(6, -1, 1, 3);
        eth0_tx_fault = 1'b1;
        wait_state(6);
        cycles(3);
        push(1, -1, 1, 3);
        sfp_clk_alarm_b = 1'b0;
        wait_state(1);
        chk("alarm_tx_disable", 32'(eth0_tx_disable), 32'd1);
        chk("alarm_eth_rst", 32'(eth_rst), 32'd1);
        push(2, -1, 1, 3); push(3, 8, 1, 3); push(4, 16, 1, 3); push(5, 1, 1, 3);
        eth0_tx_fault = 1'b0;
        sfp_clk_alarm_b = 1'b1;
        wait_state(5);

        // 5: asynchronous reset in TX_ON
        push(1, -1, 1, 3); push(2, -1, 1, 3); push(3, 8, 1, 3);
        sfp_clk_alarm_b = 1'b0;
        wait_state(1);
        sfp_clk_alarm_b = 1'b1;
        wait_state(3);
        cycles(4);
        push(0, -1, 0, 0);
        sys_rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_tx_disable", 32'(eth0_tx_disable), 32'd1);
        chk("arst_eth_rst", 32'(eth_rst), 32'd1);
        chk("arst_link_up", 32'(link_up), 32'd0);
        chk("arst_ldc", 32'(link_down_cnt), 32'd0);
        chk("arst_fc", 32'(fault_cnt), 32'd0);
        cycles(3);
        push(1, -1, 0, 0); push(2, -1, 0, 0); push(3, 8, 0, 0);
        push(4, 16, 0, 0); push(5, 1, 0, 0);
        sys_rst_n = 1'b1;
        wait_state(5);
        cycles(5);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
